// File: rtl/switch_dispatch_if.sv
// rtl/switch_dispatch_if.sv - stream-in / multicast-out bundle for the switch dispatcher
interface switch_dispatch_if #(
    parameter int NUM_OF_PORTS = 4,
    parameter int W_WIDTH      = 8
);
    logic [W_WIDTH-1:0]      data_in;
    logic                    data_valid_in;
    logic                    data_ready_out;
    logic [W_WIDTH-1:0]      cfg_addr_0;
    logic [W_WIDTH-1:0]      cfg_addr_1;
    logic [W_WIDTH-1:0]      cfg_addr_2;
    logic [W_WIDTH-1:0]      cfg_addr_3;
    logic [W_WIDTH-1:0]      port_data_out;
    logic [NUM_OF_PORTS-1:0] port_valid_out;
    logic                    port_eop_out;
    logic [NUM_OF_PORTS-1:0] port_ready_in;
    logic                    pkt_drop;
    logic                    busy;

    // Dispatcher side
    modport slave (
        input  data_in, data_valid_in,
        input  cfg_addr_0, cfg_addr_1, cfg_addr_2, cfg_addr_3,
        input  port_ready_in,
        output data_ready_out, port_data_out, port_valid_out, port_eop_out,
        output pkt_drop, busy
    );

    // Upstream source, register block and output ports
    modport master (
        output data_in, data_valid_in,
        output cfg_addr_0, cfg_addr_1, cfg_addr_2, cfg_addr_3,
        output port_ready_in,
        input  data_ready_out, port_data_out, port_valid_out, port_eop_out,
        input  pkt_drop, busy
    );
endinterface

// File: rtl/switch_dispatch.sv
// rtl/switch_dispatch.sv - per-packet DA decode and registered multicast forwarding
module switch_dispatch #(
    parameter int NUM_OF_PORTS = 4,
    parameter int W_WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    switch_dispatch_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_SA,
        S_HDR_LEN,
        S_PAYLOAD,
        S_DROP
    } state_t;

    // Position inside a dropped packet (DA already consumed)
    localparam logic [1:0] DP_SA  = 2'd0;
    localparam logic [1:0] DP_LEN = 2'd1;
    localparam logic [1:0] DP_PAY = 2'd2;

    localparam logic [W_WIDTH-1:0] ONE = W_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_OF_PORTS-1:0] r_mask;
    logic [NUM_OF_PORTS-1:0] w_mask_nxt;
    logic [W_WIDTH-1:0]      r_rem;
    logic [W_WIDTH-1:0]      w_rem_nxt;
    logic [1:0]              r_drop_phase;
    logic [1:0]              w_drop_phase_nxt;

    logic [W_WIDTH-1:0]      r_data;
    logic [NUM_OF_PORTS-1:0] r_valid;
    logic                    r_eop;
    logic                    r_drop;

    logic [NUM_OF_PORTS-1:0] w_match;
    logic                    w_fire;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_load;
    logic [NUM_OF_PORTS-1:0] w_load_mask;
    logic                    w_load_eop;
    logic                    w_drop_pulse;

    // DA compare against the live cfg; only consulted in IDLE
    assign w_match = {bus.data_in == bus.cfg_addr_3,
                      bus.data_in == bus.cfg_addr_2,
                      bus.data_in == bus.cfg_addr_1,
                      bus.data_in == bus.cfg_addr_0};

    // Fire needs every targeted port ready at once; untargeted ports are ignored
    assign w_fire = (r_valid != '0) && ((r_valid & ~bus.port_ready_in) == '0);

    // One-entry output register: accept when empty or draining this cycle.
    // Dropped bytes never touch the register, so DROP always accepts.
    assign w_ready  = (r_state == S_DROP) || (r_valid == '0) || w_fire;
    assign w_accept = bus.data_valid_in && w_ready;

    // Next-state decode: which byte is forwarded, its eop flag, and counter updates
    always_comb begin
        w_state_nxt      = r_state;
        w_mask_nxt       = r_mask;
        w_rem_nxt        = r_rem;
        w_drop_phase_nxt = r_drop_phase;
        w_load           = 1'b0;
        w_load_mask      = r_mask;
        w_load_eop       = 1'b0;
        w_drop_pulse     = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_match != '0) begin
                        w_load      = 1'b1;
                        w_load_mask = w_match;
                        w_mask_nxt  = w_match;
                        w_state_nxt = S_HDR_SA;
                    end else begin
                        w_drop_pulse     = 1'b1;
                        w_drop_phase_nxt = DP_SA;
                        w_state_nxt      = S_DROP;
                    end
                end
                S_HDR_SA: begin
                    w_load      = 1'b1;
                    w_state_nxt = S_HDR_LEN;
                end
                S_HDR_LEN: begin
                    w_load    = 1'b1;
                    w_rem_nxt = bus.data_in;
                    if (bus.data_in == '0) begin
                        w_load_eop  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_load    = 1'b1;
                    w_rem_nxt = (r_rem != '0) ? (r_rem - ONE) : '0;
                    if (r_rem <= ONE) begin
                        w_load_eop  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DROP: begin
                    case (r_drop_phase)
                        DP_SA: w_drop_phase_nxt = DP_LEN;
                        DP_LEN: begin
                            w_rem_nxt = bus.data_in;
                            if (bus.data_in == '0) begin
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_drop_phase_nxt = DP_PAY;
                            end
                        end
                        default: begin
                            w_rem_nxt = (r_rem != '0) ? (r_rem - ONE) : '0;
                            if (r_rem <= ONE) begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    endcase
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM state, latched port mask and remaining-byte counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_rem        <= '0;
            r_drop_phase <= DP_SA;
        end else begin
            r_state      <= w_state_nxt;
            r_mask       <= w_mask_nxt;
            r_rem        <= w_rem_nxt;
            r_drop_phase <= w_drop_phase_nxt;
        end
    end

    // Output register: load on forward, hold while stalled, empty after a bare fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= '0;
            r_eop   <= 1'b0;
        end else if (w_load) begin
            r_data  <= bus.data_in;
            r_valid <= w_load_mask;
            r_eop   <= w_load_eop;
        end else if (w_fire) begin
            r_valid <= '0;
            r_eop   <= 1'b0;
        end
    end

    // Single-cycle drop indication for an unmatched DA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop_pulse;
        end
    end

    assign bus.data_ready_out = w_ready;
    assign bus.port_data_out  = r_data;
    assign bus.port_valid_out = r_valid;
    assign bus.port_eop_out   = r_eop && (r_valid != '0);
    assign bus.pkt_drop       = r_drop;
    assign bus.busy           = (r_state != S_IDLE) || (r_valid != '0);

endmodule

// File: doc/switch_dispatch.md
Name: switch_dispatch

Overview:
Per-packet dispatcher for the simple switch, directly downstream of the register block.
- Consumes the four per-port address registers (cfg_addr_0..3) and an input byte stream.
- Decodes each packet's destination address (DA) and forwards the whole packet, registered, to every output port whose configured address matches the DA.
- Drops packets that match no port.
- Packet format: DA, SA, LEN, then LEN payload bytes (3+LEN bytes total).

Parameters:
NUM_OF_PORTS, 4, number of output ports; fixed at 4 to match the cfg_addr inputs.
W_WIDTH, 8, byte width of data, addresses and LEN.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
data_in  input  W_WIDTH  input packet byte.
data_valid_in  input  1  data_in valid this cycle.
data_ready_out  output  1  dispatcher can accept data_in this cycle.
cfg_addr_0..cfg_addr_3  input  W_WIDTH each  port address from the register block.
port_data_out  output  W_WIDTH  byte shared by all output ports.
port_valid_out  output  NUM_OF_PORTS  per-port valid; more than one bit may be set (multicast).
port_eop_out  output  1  current port byte is the last byte of its packet.
port_ready_in  input  NUM_OF_PORTS  per-port ready.
pkt_drop  output  1  one-cycle pulse when a DA matches no port.
busy  output  1  FSM not in IDLE, or output register holding a byte.

Behaviour:
Reset (asynchronous, rst_n=0):
- port_data_out=0, port_valid_out=0, port_eop_out=0, pkt_drop=0, busy=0; FSM=IDLE; counters=0.
- data_ready_out=1 once rst_n=1.

Handshakes:
- Input accept: data_valid_in && data_ready_out.
- Output fire: port_valid_out!=0 && (port_valid_out & ~port_ready_in)==0, i.e. all targeted ports ready simultaneously.
- Output register is one entry. data_ready_out = (port_valid_out==0) || output fire (combinational through port_ready_in).
- In DROP state, data_ready_out = 1.

Output register:
- A forwarded byte appears on port_data_out/port_valid_out the cycle after acceptance (latency 1).
- It holds stable until output fire.
- On output fire with no new accept, port_valid_out returns to 0.
- Back-to-back accept plus fire sustains 1 byte per cycle.

FSM states: IDLE, HDR_SA, HDR_LEN, PAYLOAD, DROP.
- IDLE, on accept (byte is DA):
  - mask[i] = (data_in == cfg_addr_i). Sampled here only; cfg changes later in the packet have no effect.
  - mask!=0: load the DA into the output register with port_valid_out=mask, latch mask, go to HDR_SA.
  - mask==0: pulse pkt_drop for 1 cycle, go to DROP. Dropped bytes never reach an output.
- HDR_SA, on accept: forward the byte, go to HDR_LEN.
- HDR_LEN, on accept: forward the byte, rem=data_in.
  - rem==0: this byte has port_eop_out=1, go to IDLE.
  - Otherwise go to PAYLOAD.
- PAYLOAD, on each accept: forward the byte, rem=rem-1. The byte accepted when rem==1 has port_eop_out=1, go to IDLE.
- DROP:
  - Tracks the same byte sequence (SA, LEN, payload) with its own rem count. No outputs are driven.
  - Returns to IDLE after the last byte (LEN=0: after the LEN byte).
  - pkt_drop asserts only on the DA byte.

Boundary rules:
- LEN=255 gives 258 bytes; the counter never wraps below 0.
- Duplicate cfg addresses: every matching port is set in mask (multicast).
- A port not in mask has its ready ignored.
- data_valid_in low mid-packet: the FSM holds state; there is no timeout.
- port_eop_out is qualified by port_valid_out.
- Reset mid-packet: the partial packet is abandoned. The next accepted byte after reset is treated as a DA.

Test Plan:
1. cfg=0x11,0x22,0x33,0x44, all ready=1; packet 22,05,02,AA,BB -> port_valid_out=4'b0010 for 5 consecutive cycles starting 1 cycle after the first accept, eop on BB, pkt_drop=0.
2. cfg_addr_0=cfg_addr_2=0x55, packet 55,01,00 -> port_valid_out=4'b0101, eop on the 00 byte; with port_ready_in=4'b0001, no fire and data_ready_out=0 until ready=4'b0101.
3. Packet 99,01,03,01,02,03 with no match -> pkt_drop=1 for exactly 1 cycle; port_valid_out stays 0; next packet 11,... is routed to port 0.
4. Valid toggling 1/0 every cycle and port 1 ready toggling, packet to 0x22 with LEN=4 -> all 7 bytes delivered in order, no duplication or loss, eop on byte 7.
5. rst_n=0 asserted during PAYLOAD of a LEN=10 packet -> outputs 0 immediately (asynchronous); after release, byte 33 is treated as a DA and routed to port 2.
6. cfg_addr_1 changed from 0x22 to 0x77 during PAYLOAD of a 0x22 packet -> the packet completes on port 1; the next 0x22 packet is dropped.
